// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction width, fetch defaults and the
// IF/ID pipeline payload.
package mips_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DEFAULT_IMEM_AW  = 6;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

    // IF/ID pipeline register contents handed to decode
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pcplus4;
        logic               valid;
    } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load enable, synchronous flush (to a NOP
// bubble) and asynchronous active-low reset.
//   clk, reset : clock, async active-low reset
//   en         : capture d on the rising edge
//   flush      : load a bubble; wins over en
//   d / q      : pipeline payload in / registered payload out
module if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pcplus4: '0, valid: 1'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem, and fills the IF/ID
// register. Per cycle exactly one action: redirect > stall > advance.
//   clk, reset     : clock, async active-low reset
//   stall          : hold PC, IF/ID and fetch counter
//   redirect       : load redirect_pc (word aligned) and flush IF/ID
//   redirect_pc    : branch/jump target
//   imem_rd        : instruction word at imem_addr (combinational read)
//   imem_addr      : word address, pc[IMEM_AW+1:2]
//   pc             : current fetch PC
//   ifid_*         : IF/ID register contents for decode
//   fetch_count    : fetches accepted since reset (wraps)
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_AW  = DEFAULT_IMEM_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic [31:0]        imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        pc,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pcplus4,
    output logic               ifid_valid,
    output logic [31:0]        fetch_count
);

    logic [31:0] pc_plus4;
    logic        advance;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign pc_plus4  = pc + 32'd4;
    assign advance   = !redirect && !stall;
    assign imem_addr = pc[IMEM_AW+1:2];

    // PC register; misaligned redirect targets lose their low two bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (advance) begin
            pc <= pc_plus4;
        end
    end

    // Counts accepted fetches only; stalls and redirects do not count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
        end else if (advance) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign ifid_d = '{instr: imem_rd, pcplus4: pc_plus4, valid: 1'b1};

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .en    (advance),
        .flush (redirect),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign ifid_instr   = ifid_q.instr;
    assign ifid_pcplus4 = ifid_q.pcplus4;
    assign ifid_valid   = ifid_q.valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly upstream of decode. Owns the program counter, drives the instruction memory address, and captures each fetched word with its PC+4 into the IF/ID pipeline register consumed by the controller and datapath. Handles decode stalls and branch/jump redirects (BEQ, BNE, J), flushing the wrong-path instruction. Also keeps a fetched-instruction counter for simulation bring-up.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 6, instruction memory word-address width (64 words).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserted low clears all state immediately.
- stall  in  1  decode hazard; hold PC and IF/ID.
- redirect  in  1  taken branch or jump resolved downstream.
- redirect_pc  in  32  target for redirect.
- imem_rd  in  32  instruction word from imem (combinational read).
- imem_addr  out  IMEM_AW  word address to imem, = pc[IMEM_AW+1:2].
- pc  out  32  current fetch PC.
- ifid_instr  out  32  instruction to decode.
- ifid_pcplus4  out  32  PC+4 of that instruction (branch base).
- ifid_valid  out  1  ifid_instr is a real fetched instruction.
- fetch_count  out  32  number of fetches accepted since reset.

## Operation
- Per cycle, exactly one action, priority redirect > stall > advance.
- Advance (redirect=0, stall=0): pc <= pc+4; ifid_instr <= imem_rd; ifid_pcplus4 <= pc+4; ifid_valid <= 1; fetch_count <= fetch_count+1.
- Stall (redirect=0, stall=1): pc, ifid_*, fetch_count hold.
- Redirect (redirect=1, stall ignored): pc <= {redirect_pc[31:2], 2'b00}; ifid_instr <= 32'h0000_0000 (NOP); ifid_pcplus4 <= 0; ifid_valid <= 0; fetch_count holds.
- Misaligned redirect_pc: low two bits silently dropped.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. imem_addr wraps every 2^(IMEM_AW+2) bytes.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- No FSM beyond the valid bit; ifid_valid=0 marks a bubble (post-reset or post-flush).

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC[IMEM_AW+1:2], ifid_instr=0, ifid_pcplus4=0, ifid_valid=0, fetch_count=0.
- Reset assertion mid-operation clears state asynchronously; first advance occurs at the first rising edge after reset goes high.
- imem_addr is combinational from pc; imem_rd must settle in the same cycle.
- Fetch-to-decode latency: 1 cycle (word at pc appears on ifid_instr after the next edge).
- Redirect penalty: 1 bubble; the target instruction reaches ifid_instr 2 edges after redirect is sampled.
- stall and redirect are sampled only at rising clk; no combinational path from them to outputs.

## Structure
- Shared package mips_pkg: NOP_INSTR (32'h0), RESET_PC default, IMEM_AW default, INSTR_W=32.
- One sub-module: if_id_reg (enable + synchronous flush + async active-low reset pipeline register holding instr, pcplus4, valid).
- PC register, adder and redirect mux stay in fetch_stage.

## Test plan
- Reset: hold reset low, imem returns 32'h2002_0005 -> pc=0, ifid_valid=0, ifid_instr=0, fetch_count=0.
- Sequential: release reset, imem[0..2]=32'h2002_0005, 32'h2003_000C, 32'h2067_FFF7 -> after edges 1..3 ifid_instr matches in order, ifid_pcplus4=4, 8, 12, pc=12, fetch_count=3.
- Stall: assert stall 2 cycles at pc=8 -> pc stays 8, ifid_* unchanged, fetch_count unchanged; release -> advances to pc=12.
- Redirect with stall: redirect=1, stall=1, redirect_pc=32'h0000_0043 at pc=16 -> pc=32'h40, ifid_valid=0, ifid_instr=0; next edge ifid_instr=imem[16], ifid_pcplus4=32'h44.
- Wrap: redirect_pc=32'hFFFF_FFFC, then advance -> pc=0, imem_addr=0, ifid_pcplus4=0.
- Reset mid-run: pull reset low between edges at pc=24 -> all outputs return to reset values without a clock edge.
